// File: rtl/ccff_chain_loader.sv
// Serial loader for a configuration flip-flop chain: streams host words into the
// chain head MSB first, then recirculates the chain once to check its parity.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);
  localparam logic [WCNT_W-1:0] WORD_C = WCNT_W'(WORD_W);
  localparam logic [WCNT_W-1:0] ONE_W  = WCNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;       // valid bits left in word_q
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    ver_cnt_q, ver_cnt_d;
  logic                load_par_q, load_par_d;
  logic                tail_par_q, tail_par_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                word_empty;
  logic [CNT_W-1:0]    bit_cnt_inc;

  assign word_empty  = (wcnt_q == '0);
  assign bit_cnt_inc = bit_cnt_q + ONE_C;

  // NOTE: non-blocking assignments here so every register samples the pre-edge
  // values; blocking would let later statements see already-updated state.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      wcnt_q     <= '0;
      bit_cnt_q  <= '0;
      ver_cnt_q  <= '0;
      load_par_q <= 1'b0;
      tail_par_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      wcnt_q     <= wcnt_d;
      bit_cnt_q  <= bit_cnt_d;
      ver_cnt_q  <= ver_cnt_d;
      load_par_q <= load_par_d;
      tail_par_q <= tail_par_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    state_d       = state_q;
    word_d        = word_q;
    wcnt_d        = wcnt_q;
    bit_cnt_d     = bit_cnt_q;
    ver_cnt_d     = ver_cnt_q;
    load_par_d    = load_par_q;
    tail_par_d    = tail_par_q;
    done_d        = done_q;
    err_d         = err_q;
    cfg_ready     = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d    = S_LOAD;
          done_d     = 1'b0;
          err_d      = 1'b0;
          bit_cnt_d  = '0;
          ver_cnt_d  = '0;
          load_par_d = 1'b0;
          tail_par_d = 1'b0;
          wcnt_d     = '0;
        end
      end

      S_LOAD: begin
        // Refill on the last bit's cycle as well, so a streaming host sees no bubbles.
        cfg_ready = word_empty || ((wcnt_q == ONE_W) && (bit_cnt_inc < LEN_C));
        if (!word_empty) begin
          ccff_shift_en = 1'b1;
          ccff_head     = word_q[WORD_W-1];
          word_d        = word_q << 1;
          wcnt_d        = wcnt_q - ONE_W;
          bit_cnt_d     = bit_cnt_inc;
          load_par_d    = load_par_q ^ word_q[WORD_W-1];
        end
        if (cfg_valid && cfg_ready) begin
          word_d = cfg_data;
          wcnt_d = WORD_C;
        end
        if (bit_cnt_d == LEN_C) begin
          state_d = S_VERIFY;
          wcnt_d  = '0;
        end
        if (abort) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
          done_d  = 1'b0;
        end
      end

      S_VERIFY: begin
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
        tail_par_d    = tail_par_q ^ ccff_tail;
        ver_cnt_d     = ver_cnt_q + ONE_C;
        if (ver_cnt_q == LAST_C) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = load_par_q ^ tail_par_d;
        end
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = err_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: a 16-bit and a 12-bit chain model, each driven by its own loader.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic prog_reset;

  // 16-bit chain, 8-bit words
  logic       start_a, abort_a, valid_a, flip_a;
  logic [7:0] data_a;
  logic       ready_a, head_a, sh_a, busy_a, done_a, err_a, tail_a;
  logic [15:0] chain_a = '0;

  // 12-bit chain, 8-bit words
  logic       start_b, abort_b, valid_b;
  logic [7:0] data_b;
  logic       ready_b, head_b, sh_b, busy_b, done_b, err_b, tail_b;
  logic [11:0] chain_b = '0;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start_a), .abort(abort_a),
    .cfg_data(data_a), .cfg_valid(valid_a), .cfg_ready(ready_a),
    .ccff_head(head_a), .ccff_shift_en(sh_a), .ccff_tail(tail_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start_b), .abort(abort_b),
    .cfg_data(data_b), .cfg_valid(valid_b), .cfg_ready(ready_b),
    .ccff_head(head_b), .ccff_shift_en(sh_b), .ccff_tail(tail_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Chain models: head enters at bit 0, tail leaves from the MSB.
  always @(posedge clk) if (sh_a) chain_a <= {chain_a[14:0], head_a};
  always @(posedge clk) if (sh_b) chain_b <= {chain_b[10:0], head_b};
  assign tail_a = chain_a[15] ^ flip_a;
  assign tail_b = chain_b[11];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] log_a, log_b;
  int nsh_a, acc_a, gaps_a;
  int nsh_b, acc_b, late_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; records what the
  // next rising edge will see, then advances to the following falling edge.
  task automatic step();
    #1;
    if (sh_a) begin log_a = {log_a[30:0], head_a}; nsh_a++; end
    if (busy_a && !sh_a && nsh_a > 0 && nsh_a < 16) gaps_a++;
    if (valid_a && ready_a) acc_a++;
    if (sh_b) begin log_b = {log_b[30:0], head_b}; nsh_b++; end
    if (acc_b >= 2 && ready_b) late_b++;
    if (valid_b && ready_b) acc_b++;
    @(negedge clk);
  endtask

  task automatic start_a_pulse();
    log_a = '0; nsh_a = 0; acc_a = 0; gaps_a = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  // Feeds two words to dut_a until it leaves busy; event hooks fire at a
  // given count of shifted bits (-1 disables a hook).
  task automatic feed_a(input logic [7:0] w0, input logic [7:0] w1, input int valid_period,
                        input int flip_at, input int abort_at, input int start_at,
                        input int rst_at);
    for (int c = 0; c < 200; c++) begin
      if (!busy_a) break;
      valid_a = (acc_a < 2) && (c % valid_period == 0);
      data_a  = (acc_a == 0) ? w0 : w1;
      flip_a  = (nsh_a == flip_at);
      abort_a = (nsh_a == abort_at);
      start_a = (nsh_a == start_at);
      if (nsh_a == rst_at) begin
        #2 prog_reset = 1'b0;
        #1 check("reset_mid_load_outputs",
                 32'({ready_a, head_a, sh_a, busy_a, done_a, err_a}), 32'h0);
        break;
      end
      step();
    end
    valid_a = 1'b0; flip_a = 1'b0; abort_a = 1'b0; start_a = 1'b0;
  endtask

  initial begin
    prog_reset = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; valid_a = 1'b0; flip_a = 1'b0; data_a = '0;
    start_b = 1'b0; abort_b = 1'b0; valid_b = 1'b0; data_b = '0;
    log_a = '0; log_b = '0;
    nsh_a = 0; acc_a = 0; gaps_a = 0; nsh_b = 0; acc_b = 0; late_b = 0;

    @(negedge clk);
    check("reset_outputs_a", 32'({ready_a, head_a, sh_a, busy_a, done_a, err_a}), 32'h0);
    check("reset_outputs_b", 32'({ready_b, head_b, sh_b, busy_b, done_b, err_b}), 32'h0);
    @(negedge clk);
    prog_reset = 1'b1;
    step();
    check("idle_busy", 32'(busy_a), 32'h0);

    // Nominal back-to-back words
    start_a_pulse();
    check("nom_busy_after_start", 32'({busy_a, done_a}), 32'b10);
    feed_a(8'hA5, 8'h3C, 1, -1, -1, -1, -1);
    check("nom_done_err", 32'({done_a, err_a, busy_a}), 32'b100);
    check("nom_shift_count", 32'(nsh_a), 32'd32);
    check("nom_head_bits", log_a, 32'hA53C_A53C);
    check("nom_no_bubbles", 32'(gaps_a), 32'd0);
    check("nom_chain", 32'(chain_a), 32'hA53C);
    repeat (3) step();
    check("done_no_shift", 32'(nsh_a), 32'd32);
    check("done_sticky", 32'(done_a), 32'h1);

    // Starved host: valid withheld periodically, one bubble between words
    start_a_pulse();
    check("start_clears_done", 32'(done_a), 32'h0);
    feed_a(8'hA5, 8'h3C, 3, -1, -1, -1, -1);
    check("bub_done_err", 32'({done_a, err_a}), 32'b10);
    check("bub_head_bits", log_a, 32'hA53C_A53C);
    check("bub_gap_count", 32'(gaps_a), 32'd1);
    check("bub_chain", 32'(chain_a), 32'hA53C);

    // Start pulse in mid-LOAD is ignored
    start_a_pulse();
    feed_a(8'hA5, 8'h3C, 1, -1, -1, 6, -1);
    check("startbusy_done", 32'({done_a, err_a}), 32'b10);
    check("startbusy_head_bits", log_a, 32'hA53C_A53C);
    check("startbusy_shift_count", 32'(nsh_a), 32'd32);

    // One tail bit inverted during VERIFY
    start_a_pulse();
    feed_a(8'hA5, 8'h3C, 1, 19, -1, -1, -1);
    check("fault_done_err", 32'({done_a, err_a}), 32'b11);
    start_a_pulse();
    check("fault_start_clears", 32'({busy_a, done_a, err_a}), 32'b100);

    // Abort after 5 shifted bits
    feed_a(8'hA5, 8'h3C, 1, -1, 5, -1, -1);
    check("abort_idle", 32'({busy_a, done_a, err_a}), 32'b000);
    begin
      int n_before;
      n_before = nsh_a;
      repeat (3) step();
      check("abort_no_shift", 32'(nsh_a), 32'(n_before));
    end

    // Abort and start together while idle: stays idle
    abort_a = 1'b1; start_a = 1'b1;
    step();
    abort_a = 1'b0; start_a = 1'b0;
    check("abort_beats_start", 32'(busy_a), 32'h0);

    // Reset at bit 9
    start_a_pulse();
    feed_a(8'hA5, 8'h3C, 1, -1, -1, -1, 9);
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("reset_hold_outputs", 32'({ready_a, head_a, sh_a, busy_a, done_a, err_a}), 32'h0);
    prog_reset = 1'b1;
    repeat (4) step();
    check("reset_no_shift", 32'(nsh_a), 32'd9);
    check("reset_resume_idle", 32'({busy_a, done_a}), 32'b00);
    start_a_pulse();
    feed_a(8'hA5, 8'h3C, 1, -1, -1, -1, -1);
    check("reload_done", 32'({done_a, err_a}), 32'b10);
    check("reload_chain", 32'(chain_a), 32'hA53C);

    // Partial last word on the 12-bit chain
    log_b = '0; nsh_b = 0; acc_b = 0; late_b = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!busy_b) break;
      valid_b = (acc_b < 2);
      data_b  = (acc_b == 0) ? 8'hFF : 8'h0F;
      step();
    end
    valid_b = 1'b0;
    check("part_done_err", 32'({done_b, err_b}), 32'b10);
    check("part_shift_count", 32'(nsh_b), 32'd24);
    check("part_head_bits", 32'(log_b[23:0]), 32'hFF0FF0);
    check("part_accepts", 32'(acc_b), 32'd2);
    check("part_ready_after_last", 32'(late_b), 32'd0);
    check("part_chain", 32'(chain_b), 32'hFF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
